serial_sub4: RTL and testbench

Bit-serial 4-bit subtractor for the switch/LED lab board. It is the inverse of the combinational 4-bit adder: it computes A − B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. A start pulse launches each operation. The 4-bit difference and the final borrow are shown on the same 5-LED layout the adder uses.

---
 rtl/serial_sub4.sv | 96 +++++++++
 tb/tb_serial_sub4.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub4.sv
// ============================================================================
//  Module   : serial_sub4
//  Purpose  : Bit-serial 4-bit subtractor (A - B, LSB first) with LED result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] SW,
    input  logic       start,
    output logic [4:0] LED,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        start_q;
    logic [3:0]  a_sh_q;
    logic [3:0]  b_sh_q;
    logic [3:0]  d_sh_q;
    logic        bor_q;
    logic [1:0]  cnt_q;

    logic        start_edge;
    logic        diff_bit;
    logic        bout_bit;

    assign start_edge = start & ~start_q;

    // Full-subtractor cell on the current LSBs
    assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
    assign bout_bit = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            // start_q resets high so a button held through reset cannot launch
            start_q <= 1'b1;
            state_q <= ST_IDLE;
            a_sh_q  <= 4'd0;
            b_sh_q  <= 4'd0;
            d_sh_q  <= 4'd0;
            bor_q   <= 1'b0;
            cnt_q   <= 2'd0;
            LED     <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        a_sh_q  <= SW[3:0];
                        b_sh_q  <= SW[7:4];
                        d_sh_q  <= 4'd0;
                        bor_q   <= 1'b0;
                        cnt_q   <= 2'd0;
                        busy    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q <= {1'b0, a_sh_q[3:1]};
                    b_sh_q <= {1'b0, b_sh_q[3:1]};
                    d_sh_q <= {diff_bit, d_sh_q[3:1]};
                    bor_q  <= bout_bit;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    LED     <= {bor_q, d_sh_q};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub4.sv
// ============================================================================
//  Module   : tb_serial_sub4
//  Purpose  : Self-checking bench for serial_sub4 against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub4;

    logic       clk;
    logic       rst;
    logic [7:0] SW;
    logic       start;
    logic [4:0] LED;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int done_cnt;

    serial_sub4 dut (
        .clk   (clk),
        .rst   (rst),
        .SW    (SW),
        .start (start),
        .LED   (LED),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done is stable across the negative edge, so each pulse counts once
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b);
        int r;
        r = int'(a) - int'(b);
        return 5'(r & 32'h1F);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and observes it; performs no checking itself.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output logic [4:0] led, output int lat, output int pulses,
                          output logic busy_after, output logic both_high);
        int d0;
        SW    = {b, a};
        start = 1'b1;
        tick();
        start = 1'b0;
        d0 = done_cnt;
        lat = -1;
        both_high = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (busy === 1'b1 && done === 1'b1) both_high = 1'b1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        led        = LED;
        busy_after = busy;
        tick();
        pulses = done_cnt - d0;
    endtask

    task automatic test_reset();
        logic bad;
        int   d0;
        rst   = 1'b1;
        start = 1'b1;
        SW    = 8'h39;
        tick();
        tick();
        checks++;
        if (LED !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: LED=%b busy=%b done=%b, required LED=00000 busy=0 done=0", LED, busy, done);
        end
        rst = 1'b0;
        d0  = done_cnt;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || LED !== 5'd0) bad = 1'b1;
        end
        checks++;
        if (bad || done_cnt != d0) begin
            errors++;
            $display("FAIL held_through_reset: activity seen (bad=%b, pulses=%0d), required none", bad, done_cnt - d0);
        end
        start = 1'b0;
        tick();
    endtask

    // Shared body for a directed case: checks value, latency, pulse count, busy.
    task automatic test_case(input string name, input logic [3:0] a, input logic [3:0] b,
                             input logic [4:0] exp);
        logic [4:0] led;
        int         lat, pulses;
        logic       ba, both;
        run_op(a, b, led, lat, pulses, ba, both);
        checks++;
        if (led !== exp) begin
            errors++;
            $display("FAIL %s_led: A=%0d B=%0d LED=%b, required %b", name, a, b, led, exp);
        end
        checks++;
        if (lat != 5 || pulses != 1 || ba !== 1'b0 || both !== 1'b0) begin
            errors++;
            $display("FAIL %s_timing: latency=%0d pulses=%0d busy=%b both=%b, required 5/1/0/0", name, lat, pulses, ba, both);
        end
    endtask

    task automatic test_basic();
        test_case("sub_9_3", 4'd9, 4'd3, 5'b00110);
        test_case("sub_3_9", 4'd3, 4'd9, 5'b11010);
    endtask

    task automatic test_corners();
        test_case("sub_0_0",   4'd0,  4'd0,  5'b00000);
        test_case("sub_15_15", 4'd15, 4'd15, 5'b00000);
        test_case("sub_0_1",   4'd0,  4'd1,  5'b11111);
        test_case("sub_15_0",  4'd15, 4'd0,  5'b01111);
    endtask

    task automatic test_exhaustive();
        logic [4:0] led;
        int         lat, pulses, bad;
        logic       ba, both;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            run_op(4'(i), 4'(i >> 4), led, lat, pulses, ba, both);
            if (led !== ref_sub(4'(i), 4'(i >> 4)) || lat != 5 || pulses != 1) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL exhaustive: A=%0d B=%0d LED=%b lat=%0d, required %b lat=5",
                             i & 15, i >> 4, led, lat, ref_sub(4'(i), 4'(i >> 4)));
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL exhaustive_total: %0d bad pairs, required 0", bad);
        end
    endtask

    // Random operands, random idle gaps and SW scrambled during RUN.
    task automatic test_random();
        logic [3:0] a, b;
        logic [4:0] exp;
        int         lat, d0;
        for (int n = 0; n < 24; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            exp = ref_sub(a, b);
            repeat ($urandom_range(0, 3)) tick();
            SW = {b, a};
            start = 1'b1;
            tick();
            start = 1'b0;
            d0 = done_cnt;
            lat = -1;
            for (int k = 1; k <= 12; k++) begin
                SW = 8'($urandom);
                tick();
                if (done === 1'b1) begin
                    lat = k;
                    break;
                end
            end
            checks++;
            if (LED !== exp || lat != 5) begin
                errors++;
                $display("FAIL random: A=%0d B=%0d LED=%b lat=%0d, required %b lat=5", a, b, LED, lat, exp);
            end
            tick();
            checks++;
            if (done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL random_pulses: %0d done pulses, required 1", done_cnt - d0);
            end
        end
    endtask

    task automatic test_busy_protect();
        int   d0, lat;
        logic bad;
        SW = {4'd3, 4'd9};
        start = 1'b1;
        tick();                 // E0
        start = 1'b0;
        d0 = done_cnt;
        tick();                 // E1
        SW = {4'd2, 4'd1};
        start = 1'b1;
        tick();                 // E2: edge must be ignored
        start = 1'b0;
        lat = -1;
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (LED !== 5'b00110 || lat != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_protect_result: LED=%b lat=%0d busy=%b, required 00110 lat=5 busy=0", LED, lat, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (done_cnt - d0 != 1 || bad || LED !== 5'b00110) begin
            errors++;
            $display("FAIL busy_protect_quiet: pulses=%0d busy_seen=%b LED=%b, required 1/0/00110", done_cnt - d0, bad, LED);
        end
    endtask

    task automatic test_mid_reset();
        int   d0;
        logic bad;
        checks++;
        if (LED !== 5'b00110) begin
            errors++;
            $display("FAIL mid_reset_pre: LED=%b, required 00110", LED);
        end
        SW = {4'd2, 4'd7};
        start = 1'b1;
        tick();                 // E0
        start = 1'b0;
        d0 = done_cnt;
        tick();                 // E1
        rst = 1'b1;
        tick();                 // E2 with reset
        rst = 1'b0;
        checks++;
        if (LED !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: LED=%b busy=%b done=%b, required 00000/0/0", LED, busy, done);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy !== 1'b0 || LED !== 5'd0) bad = 1'b1;
        end
        checks++;
        if (done_cnt != d0 || bad) begin
            errors++;
            $display("FAIL mid_reset_abort: pulses=%0d activity=%b, required 0/0", done_cnt - d0, bad);
        end
        test_case("after_reset_7_2", 4'd7, 4'd2, 5'b00101);
    endtask

    task automatic test_held();
        int d0;
        SW = {4'd5, 4'd12};
        start = 1'b1;
        d0 = done_cnt;
        repeat (20) tick();
        start = 1'b0;
        tick();
        checks++;
        if (done_cnt - d0 != 1 || LED !== ref_sub(4'd12, 4'd5)) begin
            errors++;
            $display("FAIL held_button: pulses=%0d LED=%b, required 1 and %b", done_cnt - d0, LED, ref_sub(4'd12, 4'd5));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        SW       = 8'h00;
        test_reset();
        test_basic();
        test_corners();
        test_exhaustive();
        test_random();
        test_busy_protect();
        test_mid_reset();
        test_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
